// File: rtl/bit_reverse_deser_if.sv
// Serial-in / word-out bundle for bit_reverse_deser.
// slave: the deserializer; master: the stream source plus word consumer.
interface bit_reverse_deser_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             s_bit;
  logic             s_valid;
  logic             s_ready;
  logic             s_clear;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output s_bit,
    output s_valid,
    output s_clear,
    output m_ready,
    input  s_ready,
    input  m_data,
    input  m_valid,
    input  bit_cnt
  );

  modport slave (
    input  s_bit,
    input  s_valid,
    input  s_clear,
    input  m_ready,
    output s_ready,
    output m_data,
    output m_valid,
    output bit_cnt
  );
endinterface

// File: rtl/bit_reverse_deser.sv
// Serial-to-parallel deserializer; REVERSE=1 puts the first bit in m_data[0].
// Ports: clk, rst_n (async low), bus (slave: s_* stream in, m_* word out, bit_cnt).
module bit_reverse_deser #(
  parameter int WIDTH   = 8,
  parameter bit REVERSE = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  bit_reverse_deser_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    COLLECT,
    FULL
  } state_t;

  state_t           state;
  logic             run;
  logic             m_valid_q;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_c;

  // Release of rst_n only takes effect one edge later, so the first
  // acceptance happens on the second rising edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  assign shifted = {sreg[WIDTH-2:0], bus.s_bit};

  assign bus.s_ready = run & ((state == COLLECT) | bus.m_ready);
  assign bus.m_valid = m_valid_q;
  assign bus.bit_cnt = cnt;

  always_comb begin
    data_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (REVERSE) begin
        data_c[i] = sreg[WIDTH-1-i];
      end else begin
        data_c[i] = sreg[i];
      end
    end
  end

  assign bus.m_data = data_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      m_valid_q <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
    end else if (run) begin
      unique case (state)
        COLLECT: begin
          if (bus.s_clear) begin
            cnt  <= '0;
            sreg <= '0;
          end else if (bus.s_valid) begin
            sreg <= shifted;
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= FULL;
              m_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FULL: begin
          // s_ready follows m_ready here, so a bit can only arrive
          // together with the handshake and starts the next word.
          if (bus.m_ready) begin
            state     <= COLLECT;
            m_valid_q <= 1'b0;
            if (bus.s_valid) begin
              sreg <= shifted;
              cnt  <= CW'(1);
            end else begin
              cnt <= '0;
            end
          end
        end
        default: begin
          state     <= COLLECT;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
